// File: rtl/slider_switch_debouncer_pkg.sv
// Shared constants and sizing helper for the slider switch debouncer.
package slider_switch_debouncer_pkg;

  localparam int SW_WIDTH          = 10;
  localparam int SW_TICK_DIV       = 50000;
  localparam int SW_DEBOUNCE_TICKS = 10;

  // Width needed to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: 2-flop synchroniser, tick-qualified debounce counter,
// stable level register and registered rise/fall strobes.
module switch_debounce_bit
  import slider_switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = SW_DEBOUNCE_TICKS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall,
  output logic o_accept
);

  localparam int               CNT_W    = cnt_w(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             r_sync1, r_sync2, r_stable, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ, w_accept;

  assign w_differ = r_sync2 ^ r_stable;
  assign w_accept = w_differ && i_tick && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_rise  <= w_accept &&  r_sync2;
      r_fall  <= w_accept && !r_sync2;
      // Any cycle where the input agrees with the stable level drops the count.
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (w_accept) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_accept = w_accept;

endmodule

// File: rtl/slider_switch_debouncer.sv
// Slider switch conditioning: shared sample-tick prescaler, per-bit debounce
// filters and a sticky change flag for software polling.
module slider_switch_debouncer
  import slider_switch_debouncer_pkg::*;
#(
  parameter int WIDTH          = SW_WIDTH,
  parameter int TICK_DIV       = SW_TICK_DIV,
  parameter int DEBOUNCE_TICKS = SW_DEBOUNCE_TICKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             chg_clear,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam int               PRE_W    = cnt_w(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic             r_changed;
  logic             w_tick;
  logic [WIDTH-1:0] w_accept;

  // With TICK_DIV=1 the counter is pinned at 0 and the tick is constant.
  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pre <= '0;
    else          r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .i_tick  (w_tick),
      .i_raw   (sw_raw[g]),
      .o_stable(sw_stable[g]),
      .o_rise  (sw_rise[g]),
      .o_fall  (sw_fall[g]),
      .o_accept(w_accept[g])
    );
  end

  // A new acceptance outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        r_changed <= 1'b0;
    else if (|w_accept)  r_changed <= 1'b1;
    else if (chg_clear)  r_changed <= 1'b0;
  end

  assign sw_changed = r_changed;

endmodule

// File: tb/tb_slider_switch_debouncer.sv
// Bench: hand-derived vector table, directed corner sequences, and random
// stimulus checked against a sliding-window reference model.
module tb_slider_switch_debouncer;

  localparam int W  = 10;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic         chg_clear = 1'b0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall;
  logic         sw_changed;

  logic [W-1:0] sw_raw_p = '0;
  logic         chg_clear_p = 1'b0;
  logic [W-1:0] stable_p, rise_p, fall_p;
  logic         changed_p;

  always #5 clk = ~clk;

  slider_switch_debouncer #(.WIDTH(W), .TICK_DIV(1), .DEBOUNCE_TICKS(DB)) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw), .chg_clear(chg_clear),
    .sw_stable(sw_stable), .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_changed(sw_changed)
  );

  slider_switch_debouncer #(.WIDTH(W), .TICK_DIV(3), .DEBOUNCE_TICKS(2)) dut_p (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw_p), .chg_clear(chg_clear_p),
    .sw_stable(stable_p), .sw_rise(rise_p), .sw_fall(fall_p), .sw_changed(changed_p)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a bit is accepted once the synchronised input has
  // disagreed with the stable level over the whole last-DB-edge window and no
  // reset or acceptance happened inside that window.
  logic [W-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
  logic         m_chg;
  int           age[W];
  logic [W-1:0] win[$];
  int           edge_n;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
    for (int i = 0; i < W; i++) age[i] = 0;
    win.delete();
    edge_n = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] ns;
    logic         any;
    ns  = m_stable;
    any = 1'b0;
    win.push_back(m_s2);
    if (win.size() > DB) void'(win.pop_front());
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      age[i]++;
      if (age[i] >= DB) begin
        logic all_diff;
        all_diff = 1'b1;
        foreach (win[k]) if (win[k][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          ns[i] = ~m_stable[i];
          if (ns[i]) m_rise[i] = 1'b1;
          else       m_fall[i] = 1'b1;
          age[i] = 0;
          any    = 1'b1;
        end
      end
    end
    m_chg    = any ? 1'b1 : (chg_clear ? 1'b0 : m_chg);
    m_stable = ns;
    m_s2     = m_s1;
    m_s1     = sw_raw;
  endtask

  // One clock edge with the inputs currently applied; returns 1 ns after it.
  task automatic cyc();
    if (reset_n) begin
      model_edge();
      edge_n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    check({tag, "_stable"}, sw_stable, m_stable);
    check({tag, "_rise"},   sw_rise,   m_rise);
    check({tag, "_fall"},   sw_fall,   m_fall);
    check({tag, "_chg"},    W'(sw_changed), W'(m_chg));
  endtask

  typedef struct {
    logic [W-1:0] raw;
    logic         clr;
    logic [W-1:0] st, ri, fa;
    logic         ch;
  } vec_t;

  function automatic vec_t mk(input logic [W-1:0] raw, input logic clr, input logic [W-1:0] st,
                              input logic [W-1:0] ri, input logic [W-1:0] fa, input logic ch);
    vec_t v;
    v.raw = raw; v.clr = clr; v.st = st; v.ri = ri; v.fa = fa; v.ch = ch;
    return v;
  endfunction

  vec_t tv[22];

  initial begin
    int rises, rise_edge, f_edge, e_step, t1, exp_a, acc_edge;
    logic seen;

    // Clean edge on bit 3, then bits 1/2 rise, then fall together with clear.
    for (int i = 0; i < 5; i++) tv[i] = mk(10'h008, 0, 10'h000, 10'h000, 10'h000, 0);
    tv[5] = mk(10'h008, 0, 10'h008, 10'h008, 10'h000, 1);
    tv[6] = mk(10'h008, 0, 10'h008, 10'h000, 10'h000, 1);
    for (int i = 7; i < 12; i++) tv[i] = mk(10'h00E, 0, 10'h008, 10'h000, 10'h000, 1);
    tv[12] = mk(10'h00E, 0, 10'h00E, 10'h006, 10'h000, 1);
    tv[13] = mk(10'h00E, 1, 10'h00E, 10'h000, 10'h000, 0);
    for (int i = 14; i < 19; i++) tv[i] = mk(10'h008, 0, 10'h00E, 10'h000, 10'h000, 0);
    tv[19] = mk(10'h008, 1, 10'h008, 10'h000, 10'h006, 1);
    tv[20] = mk(10'h008, 1, 10'h008, 10'h000, 10'h000, 0);
    tv[21] = mk(10'h008, 0, 10'h008, 10'h000, 10'h000, 0);

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stable", sw_stable, '0);
    check("rst_rise", sw_rise, '0);
    check("rst_fall", sw_fall, '0);
    check("rst_chg", W'(sw_changed), '0);
    reset_n = 1'b1;

    foreach (tv[i]) begin
      sw_raw    = tv[i].raw;
      chg_clear = tv[i].clr;
      cyc();
      check($sformatf("tbl%0d_stable", i), sw_stable, tv[i].st);
      check($sformatf("tbl%0d_rise", i), sw_rise, tv[i].ri);
      check($sformatf("tbl%0d_fall", i), sw_fall, tv[i].fa);
      check($sformatf("tbl%0d_chg", i), W'(sw_changed), W'(tv[i].ch));
      chk_model("tbl_mdl");
    end
    chg_clear = 1'b0;

    // Reset mid-debounce: bit 3 counter at 2 when reset hits.
    sw_raw = '0;
    repeat (4) cyc();
    reset_n = 1'b0;
    #1;
    check("midrst_stable", sw_stable, '0);
    check("midrst_strobes", sw_rise | sw_fall, '0);
    check("midrst_chg", W'(sw_changed), '0);
    model_reset();
    repeat (2) cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("postrst_zero", sw_stable | sw_rise | sw_fall | W'(sw_changed), '0);
    end

    // Glitch: three cycles high on bit 0 must never qualify.
    sw_raw[0] = 1'b1;
    repeat (3) cyc();
    sw_raw[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("glitch_out", sw_stable | sw_rise | W'(sw_changed), '0);
      chk_model("glitch_mdl");
    end

    // Bounce on bit 9 ending high.
    rises = 0;
    rise_edge = -1;
    f_edge = 0;
    for (int k = 0; k < 17; k++) begin
      if (k < 5) sw_raw[9] = (k % 2 == 0);
      if (k == 4) f_edge = edge_n;
      cyc();
      if (sw_rise[9]) begin
        rises++;
        rise_edge = edge_n - 1;
      end
      chk_model("bounce_mdl");
    end
    checki("bounce_rises", rises, 1);
    checki("bounce_edge", rise_edge, f_edge + 5);

    // Reset with every switch held high: all bits re-qualify and rise.
    sw_raw  = '1;
    reset_n = 1'b0;
    #1;
    check("hirst_stable", sw_stable, '0);
    model_reset();
    repeat (2) cyc();
    reset_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (sw_rise == '1) rises++;
      chk_model("hirst_mdl");
    end
    checki("hirst_rises", rises, 1);
    check("hirst_stable_end", sw_stable, '1);

    // Randomised slow-changing switches with occasional clears.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] flip;
      flip = W'($urandom) & W'($urandom) & W'($urandom);
      if ($urandom_range(0, 2) == 0) sw_raw = sw_raw ^ flip;
      chg_clear = ($urandom_range(0, 7) == 0);
      cyc();
      chk_model("rand");
    end
    chg_clear = 1'b0;

    // Prescaled instance: step on bit 5, acceptance lands on a tick edge.
    check("pre_idle", stable_p, '0);
    sw_raw_p[5] = 1'b1;
    e_step = edge_n;
    t1 = e_step + 2;
    while (t1 % 3 != 2) t1++;
    exp_a = t1 + 3;
    seen = 1'b0;
    acc_edge = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (stable_p[5]) begin
        seen = 1'b1;
        acc_edge = edge_n - 1;
        check("pre_rise", rise_p, 10'h020);
      end
    end
    checki("pre_seen", int'(seen), 1);
    checki("pre_edge", acc_edge, exp_a);
    checki("pre_window", int'(acc_edge - e_step >= 4 && acc_edge - e_step <= 7), 1);
    checki("pre_on_tick", acc_edge % 3, 2);
    cyc();
    check("pre_rise_gone", rise_p, '0);
    check("pre_hold", stable_p, 10'h020);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
